// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver.
//  - SEG_BLANK / SEG_DASH: active-low {a,b,c,d,e,f,g} patterns
//  - conv_state_t: state of the sequential binary-to-BCD converter
//  - bcd_digits_for(): decimal digits needed for a binary width, ceil(w*log10(2))
//  - seg_encode(): BCD nibble to active-low segment pattern (non-decimal -> blank)
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // log10(2) ~= 0.30103, rounded up with integer arithmetic.
  function automatic int bcd_digits_for(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Handshake: a value transfers on a rising clk edge where in_valid is high and
// state is IDLE (the parent derives in_ready from state == IDLE). in_valid is
// ignored in SHIFT and DONE; nothing is queued.
// Ports:
//  clk, rst    clock, asynchronous active-high reset
//  in_valid    new value present
//  in_value    binary value
//  in_signed   treat in_value as two's complement
//  state       converter state (also used as debug visibility)
//  digits      BCD result, digit 0 in the low nibble; valid while done
//  neg         input was negative
//  done        single-cycle strobe in DONE, result ready to commit
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int BIN_WIDTH  = 13,
  parameter int BCD_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [BIN_WIDTH-1:0]    in_value,
  input  logic                    in_signed,
  output conv_state_t             state,
  output logic [BCD_DIGITS*4-1:0] digits,
  output logic                    neg,
  output logic                    done
);

  localparam int             CW       = $clog2(BIN_WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(BIN_WIDTH - 1);

  conv_state_t             state_next;
  logic [BIN_WIDTH-1:0]    bin_q;
  logic [BIN_WIDTH-1:0]    magnitude;
  logic [BCD_DIGITS*4-1:0] bcd_q;
  logic [BCD_DIGITS*4-1:0] bcd_adj;
  logic [CW-1:0]           bit_cnt;
  logic                    accept;

  assign accept = in_valid && (state == IDLE);
  assign digits = bcd_q;

  // The most negative input negates to 2^(BIN_WIDTH-1), which still fits
  // BIN_WIDTH bits when read as unsigned, so no extra bit is needed.
  assign magnitude = (in_signed && in_value[BIN_WIDTH-1]) ?
                     (~in_value + BIN_WIDTH'(1)) : in_value;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_cnt <= '0;
      neg     <= 1'b0;
    end else if (accept) begin
      bin_q   <= magnitude;
      bcd_q   <= '0;
      bit_cnt <= '0;
      neg     <= in_signed && in_value[BIN_WIDTH-1];
    end else if (state == SHIFT) begin
      // Correct every nibble first, then shift the joined register one bit.
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      bit_cnt        <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multi-digit seven-segment scan driver.
// Converts a binary value (valid/ready) to decimal, commits it atomically,
// and time-multiplexes the digits with sign, leading-zero blanking, decimal
// points and overflow dashes.
// Ports:
//  clk, rst    clock, asynchronous active-high reset
//  in_valid    in_value/in_signed present
//  in_ready    converter idle; transfer when in_valid && in_ready
//  in_value    value to display
//  in_signed   treat in_value as two's complement
//  blank_lz    blank leading zeros (live)
//  dp_mask     decimal point per digit, bit 0 = rightmost (live)
//  busy        conversion in progress
//  anode       one-hot active-low digit enable
//  segments    active-low {a,b,c,d,e,f,g}
//  dp_n        active-low decimal point of the lit digit
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 13,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  in_value,
  input  logic                  in_signed,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            segments,
  output logic                  dp_n
);

  localparam int BCD_DIGITS = bcd_digits_for(BIN_WIDTH);
  localparam int PAD_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int IW         = $clog2(NUM_DIGITS);
  localparam int RW         = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] LAST_CNT = RW'(REFRESH_DIV - 1);

  conv_state_t             conv_state;
  logic [BCD_DIGITS*4-1:0] conv_digits;
  logic                    conv_neg;
  logic                    conv_done;
  logic [PAD_DIGITS*4-1:0] pad_digits;
  logic                    nx_ovf;
  logic [NUM_DIGITS*4-1:0] cm_digits;
  logic                    cm_neg;
  logic                    cm_ovf;
  logic [RW-1:0]           refresh_cnt;
  logic [IW-1:0]           idx;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [NUM_DIGITS-1:0]   anode_next;
  logic [6:0]              seg_next;
  logic                    dp_next;

  bin2bcd_seq #(
    .BIN_WIDTH  (BIN_WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .in_signed (in_signed),
    .state     (conv_state),
    .digits    (conv_digits),
    .neg       (conv_neg),
    .done      (conv_done)
  );

  assign in_ready = (conv_state == IDLE);
  assign busy     = ~in_ready;

  // Zero-extend so the overflow scan also works when the display has more
  // digits than the converter produces.
  assign pad_digits = (PAD_DIGITS*4)'(conv_digits);

  // A nonzero digit beyond the display (or in the sign position) cannot be shown.
  always_comb begin
    nx_ovf = 1'b0;
    for (int i = 0; i < PAD_DIGITS; i++) begin
      if (pad_digits[i*4 +: 4] != 4'd0) begin
        if (i >= NUM_DIGITS) nx_ovf = 1'b1;
        if (conv_neg && (i >= NUM_DIGITS - 1)) nx_ovf = 1'b1;
      end
    end
  end

  // Old digits remain until the converter finishes; all fields update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cm_digits <= '0;
      cm_neg    <= 1'b0;
      cm_ovf    <= 1'b0;
    end else if (conv_done) begin
      cm_digits <= pad_digits[NUM_DIGITS*4-1:0];
      cm_neg    <= conv_neg;
      cm_ovf    <= nx_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == LAST_CNT) begin
      refresh_cnt <= '0;
      idx         <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_comb begin
    zero_run   = 1'b1;
    blank_vec  = '0;
    anode_next = '1;
    seg_next   = SEG_BLANK;
    dp_next    = 1'b1;
    // blank_vec[i]: this digit and all above it are zero; digit 0 never blanks.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (cm_digits[i*4 +: 4] == 4'd0);
      blank_vec[i] = (i != 0) && zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        anode_next[i] = 1'b0;
        dp_next       = ~dp_mask[i];
        if (cm_ovf || (cm_neg && (i == NUM_DIGITS - 1))) begin
          seg_next = SEG_DASH;
        end else if (blank_lz && blank_vec[i]) begin
          seg_next = SEG_BLANK;
        end else begin
          seg_next = seg_encode(cm_digits[i*4 +: 4]);
        end
      end
    end
  end

  // Registered together so anode, segments and dp_n never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode    <= '1;
      segments <= SEG_BLANK;
      dp_n     <= 1'b1;
    end else begin
      anode    <= anode_next;
      segments <= seg_next;
      dp_n     <= dp_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: a 13-bit and a 16-bit instance (4 digits, refresh 4).
module tb_ssd_scan_driver;

  localparam int ND   = 4;
  localparam int BW   = 13;
  localparam int BW16 = 16;
  localparam int RD   = 4;
  localparam logic [6:0] P_BLANK = 7'h7F;
  localparam logic [6:0] P_DASH  = 7'b1111110;
  localparam logic [6:0] P_ZERO  = 7'b0000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_signed = 1'b0, blank_lz = 1'b0;
  logic [BW-1:0] in_value = '0;
  logic [ND-1:0] dp_mask = '0;
  logic          in_ready, busy, dp_n;
  logic [ND-1:0] anode;
  logic [6:0]    segments;

  logic            in_valid16 = 1'b0, in_signed16 = 1'b0;
  logic [BW16-1:0] in_value16 = '0;
  logic            in_ready16, busy16, dp_n16;
  logic [ND-1:0]   anode16;
  logic [6:0]      segments16;

  ssd_scan_driver #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .in_signed(in_signed), .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy),
    .anode(anode), .segments(segments), .dp_n(dp_n)
  );

  ssd_scan_driver #(.NUM_DIGITS(ND), .BIN_WIDTH(BW16), .REFRESH_DIV(RD)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_value(in_value16),
    .in_signed(in_signed16), .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy16),
    .anode(anode16), .segments(segments16), .dp_n(dp_n16)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [6:0] exp_q[$];

  logic [ND-1:0] s_an;
  logic [6:0]    s_sg;
  logic          s_dp, s_busy, s_rdy;

  // ---------------- reference model ----------------
  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return P_BLANK;
    endcase
  endfunction

  // Expected pattern of digit idx for raw value v (bw bits) from decimal arithmetic.
  function automatic logic [6:0] model_seg(input int v, input bit sgn, input int bw,
                                           input bit blank, input int idx);
    bit neg;
    int mag;
    neg = sgn && (((v >> (bw - 1)) & 1) == 1);
    mag = neg ? ((1 << bw) - v) : v;
    if (mag >= pow10(ND) || (neg && mag >= pow10(ND - 1))) return P_DASH;
    if (neg && idx == ND - 1) return P_DASH;
    if (blank && idx > 0 && mag < pow10(idx)) return P_BLANK;
    return digit_pat((mag / pow10(idx)) % 10);
  endfunction

  function automatic int idx_of(input logic [ND-1:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic sample(input bit use16);
    @(negedge clk);
    if (use16) begin
      s_an = anode16; s_sg = segments16; s_dp = dp_n16; s_busy = busy16; s_rdy = in_ready16;
    end else begin
      s_an = anode; s_sg = segments; s_dp = dp_n; s_busy = busy; s_rdy = in_ready;
    end
  endtask

  // Returns after the accepting edge; the next sample() is one edge later.
  task automatic accept(input bit use16, input int v, input bit sgn, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if ((use16 ? in_ready16 : in_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    if (use16) begin
      in_valid16 = 1'b1; in_value16 = BW16'(v); in_signed16 = sgn;
    end else begin
      in_valid = 1'b1; in_value = BW'(v); in_signed = sgn;
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_valid16 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [ND-1:0] exp_an;
    rst = 1'b1; blank_lz = 1'b0; dp_mask = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (anode !== 4'hF || segments !== P_BLANK || dp_n !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_values: anode=%b seg=%b dp_n=%b ready=%b busy=%b, want 1111 1111111 1 1 0",
               anode, segments, dp_n, in_ready, busy);
    end
    rst = 1'b0;
    for (int k = 1; k <= 2 * ND * RD; k++) begin
      sample(0);
      exp_an = ~(ND'(1) << (((k - 1) / RD) % ND));
      compared++;
      if (s_an !== exp_an) begin
        mismatched++;
        $display("FAIL scan_sequence k=%0d: anode=%b want %b", k, s_an, exp_an);
      end
      compared++;
      if (s_sg !== P_ZERO || s_dp !== 1'b1 || s_rdy !== 1'b1) begin
        mismatched++;
        $display("FAIL reset_display k=%0d: seg=%b dp_n=%b ready=%b want %b 1 1", k, s_sg, s_dp, s_rdy, P_ZERO);
      end
    end
  endtask

  task automatic test_convert_1234();
    logic [6:0] tbl [ND];
    logic [6:0] e;
    bit ok;
    int i;
    tbl[0] = 7'b1001100; tbl[1] = 7'b0000110; tbl[2] = 7'b0010010; tbl[3] = 7'b1001111;
    blank_lz = 1'b0; dp_mask = 4'b0101;
    accept(0, 1234, 0, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL accept_1234: in_ready stayed low, got 0 want 1");
      return;
    end
    for (int k = 0; k < 16 + 2 * ND * RD; k++) begin
      sample(0);
      i = idx_of(s_an);
      compared++;
      if (s_busy !== (k <= 13) || s_rdy !== (k > 13)) begin
        mismatched++;
        $display("FAIL busy_1234 k=%0d: busy=%b ready=%b want %b %b", k, s_busy, s_rdy, k <= 13, k > 13);
      end
      compared++;
      if (i < 0) begin
        mismatched++;
        $display("FAIL anode_1234 k=%0d: anode=%b want one-hot-low", k, s_an);
      end else begin
        e = (k <= 14) ? P_ZERO : tbl[i];
        compared++;
        if (s_sg !== e || s_dp !== ~dp_mask[i]) begin
          mismatched++;
          $display("FAIL digits_1234 k=%0d idx=%0d: seg=%b dp_n=%b want %b %b", k, i, s_sg, s_dp, e, ~dp_mask[i]);
        end
      end
    end
  endtask

  task automatic test_signed_blank();
    logic [6:0] tbl [ND];
    bit ok;
    int i;
    tbl[0] = 7'b0100100; tbl[1] = P_BLANK; tbl[2] = P_BLANK; tbl[3] = P_DASH;
    blank_lz = 1'b1; dp_mask = 4'b0010;
    accept(0, 'h1FFB, 1, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL accept_minus5: in_ready stayed low, got 0 want 1");
      return;
    end
    repeat (16) sample(0);
    for (int k = 0; k < 2 * ND * RD; k++) begin
      sample(0);
      i = idx_of(s_an);
      compared++;
      if (i < 0 || s_sg !== tbl[i < 0 ? 0 : i] || s_dp !== ~dp_mask[i < 0 ? 0 : i]) begin
        mismatched++;
        $display("FAIL minus5 k=%0d: anode=%b seg=%b dp_n=%b want digit pattern %b", k, s_an, s_sg, s_dp, tbl[i < 0 ? 0 : i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    bit ok;
    int i;
    blank_lz = 1'b0; dp_mask = 4'b0000;
    accept(0, 7, 0, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL accept_7: in_ready stayed low, got 0 want 1");
      return;
    end
    sample(0);
    in_valid = 1'b1; in_value = BW'(42); in_signed = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      sample(0);
      if (k == 15) in_valid = 1'b0;
      compared++;
      if (s_rdy !== (k == 14 || k >= 29)) begin
        mismatched++;
        $display("FAIL b2b_ready k=%0d: ready=%b want %b", k, s_rdy, (k == 14 || k >= 29));
      end
      i = idx_of(s_an);
      if (k <= 14)      e = model_seg('h1FFB, 1, BW, 0, i);
      else if (k <= 29) e = model_seg(7, 0, BW, 0, i);
      else              e = model_seg(42, 0, BW, 0, i);
      compared++;
      if (i < 0 || s_sg !== e) begin
        mismatched++;
        $display("FAIL b2b_display k=%0d: anode=%b seg=%b want %b", k, s_an, s_sg, e);
      end
    end
  endtask

  task automatic test_overflow16();
    int vals [3];
    bit sgns [3];
    logic [6:0] e;
    bit ok;
    int i;
    vals[0] = 12345;        sgns[0] = 1'b0;
    vals[1] = 65536 - 1000; sgns[1] = 1'b1;
    vals[2] = 65536 - 999;  sgns[2] = 1'b1;
    blank_lz = 1'b1; dp_mask = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      accept(1, vals[c], sgns[c], ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL accept16 case=%0d: in_ready stayed low, got 0 want 1", c);
        continue;
      end
      repeat (20) sample(1);
      for (int k = 0; k < 2 * ND * RD; k++) begin
        sample(1);
        i = idx_of(s_an);
        e = (c < 2 || i == 3) ? P_DASH : 7'b0000100;
        compared++;
        if (i < 0 || s_sg !== e) begin
          mismatched++;
          $display("FAIL ovf16 case=%0d k=%0d: anode=%b seg=%b want %b", c, k, s_an, s_sg, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    bit ok;
    int i;
    blank_lz = 1'b0; dp_mask = 4'b0000;
    accept(0, 5678, 0, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL accept_5678: in_ready stayed low, got 0 want 1");
      return;
    end
    for (int k = 0; k <= 5; k++) sample(0);
    rst = 1'b1;
    #1;
    compared++;
    if (anode !== 4'hF || segments !== P_BLANK || dp_n !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: anode=%b seg=%b dp_n=%b ready=%b busy=%b want 1111 1111111 1 1 0",
               anode, segments, dp_n, in_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * RD; k++) begin
      sample(0);
      compared++;
      if (s_sg !== P_ZERO) begin
        mismatched++;
        $display("FAIL after_reset k=%0d: seg=%b want %b", k, s_sg, P_ZERO);
      end
    end
    accept(0, 5678, 0, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL reaccept_5678: in_ready stayed low, got 0 want 1");
      return;
    end
    repeat (16) sample(0);
    for (int k = 0; k < ND * RD; k++) begin
      sample(0);
      i = idx_of(s_an);
      e = model_seg(5678, 0, BW, 0, i);
      compared++;
      if (i < 0 || s_sg !== e) begin
        mismatched++;
        $display("FAIL reconvert k=%0d: anode=%b seg=%b want %b", k, s_an, s_sg, e);
      end
    end
  endtask

  task automatic test_random();
    int vals [7];
    bit sgns [7];
    int v;
    bit sgn, blank, ok;
    int i;
    vals[0] = 0;       sgns[0] = 0;
    vals[1] = 8191;    sgns[1] = 0;
    vals[2] = 'h1C19;  sgns[2] = 1;
    vals[3] = 'h1C18;  sgns[3] = 1;
    vals[4] = 'h1000;  sgns[4] = 1;
    vals[5] = 'h1000;  sgns[5] = 0;
    vals[6] = 'h1FFF;  sgns[6] = 1;
    for (int n = 0; n < 23; n++) begin
      if (n < 7) begin
        v = vals[n]; sgn = sgns[n];
      end else begin
        v = $urandom_range(0, (1 << BW) - 1); sgn = 1'($urandom_range(0, 1));
      end
      blank = 1'($urandom_range(0, 1));
      blank_lz = blank;
      dp_mask = ND'($urandom_range(0, 15));
      accept(0, v, sgn, ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL accept_rand n=%0d: in_ready stayed low, got 0 want 1", n);
        continue;
      end
      for (int d = 0; d < ND; d++) exp_q.push_back(model_seg(v, sgn, BW, blank, d));
      repeat (16) sample(0);
      for (int k = 0; k < ND * RD; k++) begin
        sample(0);
        i = idx_of(s_an);
        compared++;
        if (i < 0 || s_sg !== exp_q[i < 0 ? 0 : i] || s_dp !== ~dp_mask[i < 0 ? 0 : i]) begin
          mismatched++;
          $display("FAIL rand n=%0d v=%0h sgn=%0d blank=%0d: anode=%b seg=%b dp_n=%b want %b %b",
                   n, v, sgn, blank, s_an, s_sg, s_dp, exp_q[i < 0 ? 0 : i], ~dp_mask[i < 0 ? 0 : i]);
        end
      end
      exp_q.delete();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_convert_1234();
    test_signed_blank();
    test_back_to_back();
    test_overflow16();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
